// File: rtl/matrix_4x4_mult_core_pkg.sv
// Shared constants, FSM encoding and fixed-point saturation helper for the
// 4x4 matrix multiply core.
package matrix_pkg;

    localparam int W    = 12;
    localparam int FRAC = 10;
    localparam int N    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        COMPUTE = 2'd2,
        STREAM  = 2'd3
    } state_e;

    // Clamp a wide signed value into the W-bit two's complement range.
    function automatic logic [W-1:0] fxp_sat(input logic signed [2*W+1:0] x);
        logic [W-1:0] r;
        if ((&x[2*W+1:W-1]) || (~|x[2*W+1:W-1])) begin
            r = x[W-1:0];
        end else if (x[2*W+1]) begin
            r = {1'b1, {(W-1){1'b0}}};
        end else begin
            r = {1'b0, {(W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_4x4_mult_core_if.sv
// Operand-capture and result-stream signals of the matrix multiply core.
// aCk[r] = A[r][k-1], bCk[r] = B[r][k-1].
interface matrix_4x4_mult_core_if;
    import matrix_pkg::*;

    logic               valid_in;
    logic               ready_out;
    logic [N-1:0][W-1:0] aC1;
    logic [N-1:0][W-1:0] aC2;
    logic [N-1:0][W-1:0] aC3;
    logic [N-1:0][W-1:0] aC4;
    logic [N-1:0][W-1:0] bC1;
    logic [N-1:0][W-1:0] bC2;
    logic [N-1:0][W-1:0] bC3;
    logic [N-1:0][W-1:0] bC4;
    logic [W-1:0]        c_out;
    logic                valid_out;
    logic                ready_in;
    logic                last_out;

    modport slave (
        input  valid_in, aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4, ready_in,
        output ready_out, c_out, valid_out, last_out
    );

    modport master (
        output valid_in, aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4, ready_in,
        input  ready_out, c_out, valid_out, last_out
    );

endinterface

// File: rtl/matrix_4x4_mult_core_fxp_dot4.sv
// Combinational 4-term fixed-point dot product: full-precision sum,
// floor shift by FRAC, then saturation to W bits.
module fxp_dot4
    import matrix_pkg::*;
(
    input  logic [N-1:0][W-1:0] a_vec,
    input  logic [N-1:0][W-1:0] b_vec,
    output logic [W-1:0]        dot
);

    logic signed [2*W-1:0] prod_s [N];
    logic signed [2*W+1:0] sum_s;
    logic signed [2*W+1:0] shift_s;

    // Operands are sign-extended to 2W so the product is exact in 2W bits.
    always_comb begin
        sum_s = {(2*W+2){1'b0}};
        for (int k = 0; k < N; k++) begin
            prod_s[k] = $signed({{W{a_vec[k][W-1]}}, a_vec[k]})
                      * $signed({{W{b_vec[k][W-1]}}, b_vec[k]});
            sum_s = sum_s + {{2{prod_s[k][2*W-1]}}, prod_s[k]};
        end
    end

    assign shift_s = sum_s >>> FRAC;
    assign dot     = fxp_sat(shift_s);

endmodule

// File: rtl/matrix_4x4_mult_core.sv
// Captures A and B in one handshake, computes C = A x B one element per
// cycle and streams C out column-major (idx = 4*j + i -> C[i][j]).
module matrix_4x4_mult_core
    import matrix_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    matrix_4x4_mult_core_if.slave  bus
);

    state_e              state_r;
    state_e              state_s;
    logic [3:0]          idx_r;
    logic [3:0]          idx_s;
    logic                ready_r;
    logic                ready_s;
    logic                valid_r;
    logic                valid_s;
    logic                last_r;
    logic                last_s;
    logic [W-1:0]        c_r;
    logic [W-1:0]        c_s;
    logic                capture_s;
    logic [W-1:0]        a_r [N][N];
    logic [W-1:0]        b_r [N][N];
    logic [W-1:0]        res_r [16];
    logic [N-1:0][W-1:0] a_vec_s;
    logic [N-1:0][W-1:0] b_vec_s;
    logic [W-1:0]        dot_s;

    assign bus.ready_out = ready_r;
    assign bus.valid_out = valid_r;
    assign bus.last_out  = last_r;
    assign bus.c_out     = c_r;

    // Row i of A and column j of B for the element selected by idx.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            a_vec_s[k] = a_r[idx_r[1:0]][k];
            b_vec_s[k] = b_r[k][idx_r[3:2]];
        end
    end

    fxp_dot4 u_dot (
        .a_vec (a_vec_s),
        .b_vec (b_vec_s),
        .dot   (dot_s)
    );

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        ready_s   = ready_r;
        valid_s   = valid_r;
        last_s    = last_r;
        c_s       = c_r;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (bus.valid_in && ready_r) begin
                    capture_s = 1'b1;
                    state_s   = RELEASE;
                end else begin
                    state_s   = IDLE;
                end
            end
            RELEASE: begin
                // Upstream may hold valid for several cycles; wait for it to drop.
                if (!bus.valid_in) begin
                    state_s = COMPUTE;
                    idx_s   = 4'd0;
                    ready_s = 1'b0;
                end else begin
                    ready_s = 1'b1;
                end
            end
            COMPUTE: begin
                ready_s = 1'b0;
                if (idx_r == 4'd15) begin
                    state_s = STREAM;
                    idx_s   = 4'd0;
                    valid_s = 1'b1;
                    last_s  = 1'b0;
                    c_s     = res_r[0];
                end else begin
                    idx_s   = idx_r + 4'd1;
                end
            end
            STREAM: begin
                if (valid_r && bus.ready_in) begin
                    if (idx_r == 4'd15) begin
                        state_s = IDLE;
                        idx_s   = 4'd0;
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        ready_s = 1'b1;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                        c_s     = res_r[idx_r + 4'd1];
                        last_s  = (idx_r == 4'd14);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 4'd0;
                ready_s = 1'b0;
                valid_s = 1'b0;
                last_s  = 1'b0;
                c_s     = {W{1'b0}};
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 4'd0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            c_r     <= {W{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            ready_r <= ready_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            c_r     <= c_s;
        end
    end

    // Operand capture and per-element result storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    a_r[r][k] <= {W{1'b0}};
                    b_r[r][k] <= {W{1'b0}};
                end
            end
            for (int e = 0; e < 16; e++) begin
                res_r[e] <= {W{1'b0}};
            end
        end else begin
            if (capture_s) begin
                for (int r = 0; r < N; r++) begin
                    a_r[r][0] <= bus.aC1[r];
                    a_r[r][1] <= bus.aC2[r];
                    a_r[r][2] <= bus.aC3[r];
                    a_r[r][3] <= bus.aC4[r];
                    b_r[r][0] <= bus.bC1[r];
                    b_r[r][1] <= bus.bC2[r];
                    b_r[r][2] <= bus.bC3[r];
                    b_r[r][3] <= bus.bC4[r];
                end
            end
            if (state_r == COMPUTE) begin
                res_r[idx_r] <= dot_s;
            end
        end
    end

endmodule

// File: tb/tb_matrix_4x4_mult_core.sv
// Directed and random checks of matrix_4x4_mult_core against an integer
// reference model of C = A x B with floor shift and saturation.
module tb_matrix_4x4_mult_core;
    import matrix_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   A [4][4];
    int   B [4][4];

    matrix_4x4_mult_core_if bus ();

    matrix_4x4_mult_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, floor division by 2^10, clamp to 12-bit signed.
    function automatic int ref_elem(input int i, input int j);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += A[i][k] * B[k][j];
        s = s >>> 10;
        if (s > 2047) s = 2047;
        else if (s < -2048) s = -2048;
        return s;
    endfunction

    task automatic drive_ops();
        for (int r = 0; r < 4; r++) begin
            bus.aC1[r] = 12'(A[r][0]);
            bus.aC2[r] = 12'(A[r][1]);
            bus.aC3[r] = 12'(A[r][2]);
            bus.aC4[r] = 12'(A[r][3]);
            bus.bC1[r] = 12'(B[r][0]);
            bus.bC2[r] = 12'(B[r][1]);
            bus.bC3[r] = 12'(B[r][2]);
            bus.bC4[r] = 12'(B[r][3]);
        end
    endtask

    task automatic scramble_ops();
        for (int r = 0; r < 4; r++) begin
            bus.aC1[r] = 12'($urandom);
            bus.aC2[r] = 12'($urandom);
            bus.aC3[r] = 12'($urandom);
            bus.aC4[r] = 12'($urandom);
            bus.bC1[r] = 12'($urandom);
            bus.bC2[r] = 12'($urandom);
            bus.bC3[r] = 12'($urandom);
            bus.bC4[r] = 12'($urandom);
        end
    endtask

    task automatic randomize_mats();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                A[r][c] = int'($urandom_range(4095, 0)) - 2048;
                B[r][c] = int'($urandom_range(4095, 0)) - 2048;
            end
        end
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_mid_last",  32'(bus.last_out),  32'd0);
        chk("rst_mid_c",     32'(bus.c_out),     32'd0);
        chk("rst_mid_ready", 32'(bus.ready_out), 32'd0);
        bus.ready_in = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_rel_ready_pre", 32'(bus.ready_out), 32'd0);
        step();
        chk("rst_rel_ready", 32'(bus.ready_out), 32'd1);
        chk("rst_rel_valid", 32'(bus.valid_out), 32'd0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("rst_no_residue", 32'(bus.valid_out), 32'd0);
        end
    endtask

    // One full operand capture, compute and stream of the current A/B.
    task automatic run_pair(input int hold, input int stall_beat, input int stall_len,
                            input bit rand_ready, input int reset_beat);
        int exp_c [16];
        int beat;
        int budget;
        int stall_left;
        bit did_reset;
        for (int b = 0; b < 16; b++) exp_c[b] = ref_elem(b % 4, b / 4);
        drive_ops();
        bus.ready_in = 1'b0;
        budget = 0;
        while (bus.ready_out !== 1'b1 && budget < 50) begin
            step();
            budget++;
        end
        chk("ready_wait", 32'(bus.ready_out), 32'd1);
        bus.valid_in = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("ready_hold", 32'(bus.ready_out), 32'd1);
        end
        bus.valid_in = 1'b0;
        scramble_ops();
        step();
        chk("ready_drop", 32'(bus.ready_out), 32'd0);
        for (int n = 0; n < 15; n++) step();
        chk("latency_pre", 32'(bus.valid_out), 32'd0);
        step();
        chk("latency_first", 32'(bus.valid_out), 32'd1);

        beat = 0;
        budget = 0;
        stall_left = stall_len;
        did_reset = 1'b0;
        while (beat < 16 && budget < 400 && !did_reset) begin
            budget++;
            if (beat == reset_beat) begin
                mid_reset();
                did_reset = 1'b1;
            end else begin
                chk($sformatf("valid_b%0d", beat), 32'(bus.valid_out), 32'd1);
                chk($sformatf("c_out_b%0d", beat), 32'(bus.c_out), 32'(exp_c[beat] & 32'hFFF));
                chk($sformatf("last_b%0d", beat), 32'(bus.last_out), (beat == 15) ? 32'd1 : 32'd0);
                if (beat == stall_beat && stall_left > 0) begin
                    bus.ready_in = 1'b0;
                    stall_left--;
                end else if (rand_ready) begin
                    bus.ready_in = 1'($urandom_range(1, 0));
                end else begin
                    bus.ready_in = 1'b1;
                end
                if (bus.ready_in) beat++;
                step();
            end
        end
        if (!did_reset) begin
            chk("stream_count", 32'(beat), 32'd16);
            chk("post_valid", 32'(bus.valid_out), 32'd0);
            chk("post_last",  32'(bus.last_out),  32'd0);
            chk("post_ready", 32'(bus.ready_out), 32'd1);
        end
        bus.ready_in = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                A[r][c] = 0;
                B[r][c] = 0;
            end
        end
        drive_ops();
        step();
        step();
        chk("reset_ready", 32'(bus.ready_out), 32'd0);
        chk("reset_valid", 32'(bus.valid_out), 32'd0);
        chk("reset_last",  32'(bus.last_out),  32'd0);
        chk("reset_c",     32'(bus.c_out),     32'd0);
        rst_n = 1'b1;
        chk("ready_before_edge", 32'(bus.ready_out), 32'd0);
        step();
        chk("ready_first_edge", 32'(bus.ready_out), 32'd1);

        // Identity times ramp: stream reproduces B column-major.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                A[r][c] = (r == c) ? 1024 : 0;
                B[r][c] = 16 * (4 * r + c);
            end
        end
        run_pair(1, -1, 0, 1'b0, -1);

        // Positive saturation.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                A[r][c] = 2047;
                B[r][c] = 2047;
            end
        end
        run_pair(2, -1, 0, 1'b0, -1);

        // -1.0 diagonal times 0.5 everywhere.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                A[r][c] = (r == c) ? -1024 : 0;
                B[r][c] = 512;
            end
        end
        run_pair(1, -1, 0, 1'b0, -1);

        // Floor: tiny positive product truncates to zero.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                A[r][c] = 0;
                B[r][c] = 0;
            end
        end
        A[0][0] = 1;
        B[0][0] = 1;
        run_pair(1, -1, 0, 1'b0, -1);

        // Floor: tiny negative product rounds down to -1 LSB.
        A[0][0] = -1;
        run_pair(1, -1, 0, 1'b0, -1);

        // Valid held four cycles, 5-cycle stall on element 7.
        randomize_mats();
        run_pair(4, 7, 5, 1'b0, -1);

        // Random operands with random backpressure.
        for (int t = 0; t < 3; t++) begin
            randomize_mats();
            run_pair(int'($urandom_range(4, 1)), -1, 0, 1'b1, -1);
        end

        // Reset during streaming at element 9, then a clean recovery run.
        randomize_mats();
        run_pair(1, -1, 0, 1'b0, 9);
        randomize_mats();
        run_pair(3, 2, 3, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
